// File: rtl/arith_left_shift_seq.sv
// Sequential arithmetic left shifter: one bit per clock, sticky overflow, Start/Done handshake.
// Optional feature: define SATURATE_EN to clamp Out to the signed limit on overflow.
module arith_left_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [AMT_W-1:0] Amount,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Ovf
);

  // state   | meaning
  // S_IDLE  | waiting for Start; Out/Ovf hold the last result
  // S_SHIFT | shifting acc left one bit per cycle, cnt counts down to 1
  // S_DONE  | Out/Ovf valid, Done pulses for one cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [AMT_W-1:0] cnt, cnt_next;
  logic             ovf_acc, ovf_acc_next;
  logic             step_ovf;
  logic             load;
  logic [WIDTH-1:0] result;

`ifdef SATURATE_EN
  logic             sign, sign_next;
  logic [WIDTH-1:0] sat_val;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    cnt_next     = cnt;
    ovf_acc_next = ovf_acc;
    load         = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    // Overflow is judged on the operand before it moves: a sign change about to happen.
    step_ovf     = acc[WIDTH-1] ^ acc[WIDTH-2];
`ifdef SATURATE_EN
    sign_next    = sign;
`endif
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          acc_next     = In1;
          cnt_next     = Amount;
          ovf_acc_next = 1'b0;
`ifdef SATURATE_EN
          sign_next    = In1[WIDTH-1];
`endif
          if (Amount == '0) begin
            state_next = S_DONE;
            load       = 1'b1;
          end else begin
            state_next = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        Busy         = 1'b1;
        acc_next     = {acc[WIDTH-2:0], 1'b0};
        cnt_next     = cnt - AMT_W'(1);
        ovf_acc_next = ovf_acc | step_ovf;
        if (cnt == AMT_W'(1)) begin
          state_next = S_DONE;
          load       = 1'b1;
        end
      end
      S_DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Result is registered on entry to DONE so Out/Ovf are already valid while Done is high.
`ifdef SATURATE_EN
  always_comb begin
    sat_val = sign_next ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    result  = ovf_acc_next ? sat_val : acc_next;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sign <= 1'b0;
    end else begin
      sign <= sign_next;
    end
  end
`else
  always_comb begin
    result = acc_next;
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      Out     <= '0;
      Ovf     <= 1'b0;
    end else begin
      acc     <= acc_next;
      cnt     <= cnt_next;
      ovf_acc <= ovf_acc_next;
      if (load) begin
        Out <= result;
        Ovf <= ovf_acc_next;
      end
    end
  end

endmodule

// File: tb/tb_arith_left_shift_seq.sv
// Directed bench for arith_left_shift_seq with a scoreboard of expected results.
module tb_arith_left_shift_seq;
  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Start;
  logic [WIDTH-1:0] In1;
  logic [AMT_W-1:0] Amount;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;
  logic             Ovf;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ovf;
    int               edge_at;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   passed   = 0;
  int   total    = 0;
  logic [WIDTH-1:0] last_out;

  arith_left_shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .In1(In1), .Amount(Amount),
    .Busy(Busy), .Done(Done), .Out(Out), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input int amt, input int edge_at);
    exp_t e;
    logic [WIDTH-1:0] v;
    logic ov;
    v  = a;
    ov = 1'b0;
    for (int i = 0; i < amt; i++) begin
      if (v[WIDTH-1] != v[WIDTH-2]) ov = 1'b1;
      v = v << 1;
    end
`ifdef SATURATE_EN
    if (ov) v = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    e.out = v;
    e.ovf = ov;
    e.edge_at = edge_at;
    return e;
  endfunction

  // Drives Start for one cycle from a negedge and records the expected result.
  task automatic start_op(input logic [WIDTH-1:0] a, input int amt);
    Start  = 1'b1;
    In1    = a;
    Amount = AMT_W'(amt);
    sb.push_back(model(a, amt, edge_cnt + 1 + amt));
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge Clk);
    end
    if (!found) begin
      check({tag, "_timeout"}, 32'(Done), 32'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_out"}, 32'(Out), 32'(e.out));
      check({tag, "_ovf"}, 32'(Ovf), 32'(e.ovf));
      check({tag, "_latency"}, 32'(edge_cnt), 32'(e.edge_at));
      check({tag, "_busy_in_done"}, 32'(Busy), 32'd1);
      last_out = e.out;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (Done === 1'b1) seen++;
      @(negedge Clk);
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; Start = 1'b0; In1 = '0; Amount = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 1: basic shift, busy across cycles 1..3
    start_op(8'h05, 2);
    check("t1_busy_c1", 32'(Busy), 32'd1);
    check("t1_done_c1", 32'(Done), 32'd0);
    wait_done("t1");
    @(negedge Clk);
    check("t1_done_pulse", 32'(Done), 32'd0);
    check("t1_busy_idle", 32'(Busy), 32'd0);
    repeat (3) @(negedge Clk);
    check("t1_hold_out", 32'(Out), 32'(last_out));

    // 2: negative operand, then Start during Done is ignored, back-to-back amount 0
    start_op(8'hF0, 3);
    wait_done("t2a");
    Start = 1'b1; In1 = 8'h7E; Amount = 3'd0;
    @(negedge Clk);
    Start = 1'b0;
    check("t2_ignored_start_done", 32'(Done), 32'd0);
    start_op(8'h33, 0);
    wait_done("t2b");
    @(negedge Clk);
    check("t2b_idle", 32'(Busy), 32'd0);

    // 3: overflow cases
    start_op(8'h40, 1);
    wait_done("t3a");
    @(negedge Clk);
    start_op(8'h90, 1);
    wait_done("t3b");
    @(negedge Clk);

    // 4: Start while busy is ignored
    start_op(8'h01, 7);
    @(negedge Clk);
    Start = 1'b1; In1 = 8'hFF; Amount = 3'd1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("t4");
    @(negedge Clk);
    expect_quiet("t4_no_extra_done", 6);
    check("t4_hold_out", 32'(Out), 32'(last_out));

    // 5: reset mid-operation aborts without Done
    Start = 1'b1; In1 = 8'h11; Amount = 3'd5;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_out", 32'(Out), 32'd0);
    check("t5_ovf", 32'(Ovf), 32'd0);
    check("t5_done", 32'(Done), 32'd0);
    Rst_n = 1'b1;
    expect_quiet("t5_no_done_after_abort", 8);
    start_op(8'h05, 2);
    wait_done("t5_restart");
    @(negedge Clk);

    // a few more patterns, including maximum shift of a negative value
    start_op(8'hC3, 1);
    wait_done("t6a");
    @(negedge Clk);
    start_op(8'hFF, 7);
    wait_done("t6b");
    @(negedge Clk);
    start_op(8'h80, 0);
    wait_done("t6c");
    @(negedge Clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
